// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the data-memory arbiter and the
// single-port word-addressed data memory.
//   slave  : the arbiter's view (requests in, acks/read data/memory controls out)
//   master : the environment's view (the two requesters plus the memory)
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // Master 0 (CPU load/store unit)
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [3:0]        m0_be;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;

  // Master 1 (UART debug loader / program-load path)
  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [3:0]        m1_be;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;

  // Data memory side
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_read_data;

  // Status
  logic              busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_be,
    output m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_be,
    output m1_ack, m1_rdata,
    output mem_addr, mem_write_data, mem_read, mem_write,
    input  mem_read_data,
    output busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_be,
    input  m0_ack, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_be,
    input  m1_ack, m1_rdata,
    input  mem_addr, mem_write_data, mem_read, mem_write,
    output mem_read_data,
    input  busy
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter with byte-enable stores.
// One memory transaction is in flight at a time. Partial-word stores are
// turned into a read-modify-write because the memory only writes whole words.
// Optional macro DMEM_ARB_RR_EN: round-robin arbitration between the masters.
// Without it, master 0 has fixed priority and no round-robin pointer exists.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    MERGE_WR,
    RESP
  } state_t;

  state_t state_q, state_d;

  // Latched transaction of the granted master
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;

  // RMW merge word and per-master read data holding registers
  logic [DATA_W-1:0] merge_q, merge_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  // Combinational helpers
  logic              any_req;
  logic              pick_m1;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] merged_word;
  logic              mem_rd;
  logic              mem_wr;
  logic              ack_pulse;

  assign any_req = bus.m0_req | bus.m1_req;

`ifdef DMEM_ARB_RR_EN
  // Round-robin pointer: names the master that wins the next contended grant
  logic rr_q, rr_d;

  // Contended requests go to the pointed master; a lone requester always wins
  always_comb begin
    pick_m1 = bus.m1_req;
    if (bus.m0_req && bus.m1_req) begin
      pick_m1 = rr_q;
    end
  end

  // After every grant the pointer moves to the master that was not served
  always_comb begin
    rr_d = rr_q;
    if (state_q == IDLE && any_req) begin
      rr_d = ~pick_m1;
    end
  end

  // Pointer register, starts at master 0
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  // Fixed priority: master 1 only wins when master 0 is not requesting
  always_comb begin
    pick_m1 = bus.m1_req & ~bus.m0_req;
  end
`endif

  // Address of the winning request, forced to a word boundary
  always_comb begin
    sel_addr = pick_m1 ? bus.m1_addr : bus.m0_addr;
    sel_addr[1:0] = 2'b00;
  end

  // Byte-lane merge: new byte where enabled, otherwise keep the memory byte
  always_comb begin
    merged_word = bus.mem_read_data;
    for (int lane = 0; lane < 4; lane++) begin
      if (be_q[lane]) begin
        merged_word[8*lane +: 8] = wdata_q[8*lane +: 8];
      end
    end
  end

  // Next-state, latching and memory strobes for the transaction sequencer
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    merge_d  = merge_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = pick_m1;
          addr_d  = sel_addr;
          if (pick_m1) begin
            we_d    = bus.m1_we;
            wdata_d = bus.m1_wdata;
            be_d    = bus.m1_be;
          end else begin
            we_d    = bus.m0_we;
            wdata_d = bus.m0_wdata;
            be_d    = bus.m0_be;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          mem_rd = 1'b1;
          if (grant_q) begin
            rdata1_d = bus.mem_read_data;
          end else begin
            rdata0_d = bus.mem_read_data;
          end
          state_d = RESP;
        end else if (be_q == 4'b1111) begin
          mem_wr  = 1'b1;
          state_d = RESP;
        end else if (be_q == 4'b0000) begin
          state_d = RESP;
        end else begin
          mem_rd  = 1'b1;
          merge_d = merged_word;
          state_d = MERGE_WR;
        end
      end
      MERGE_WR: begin
        mem_wr  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= 4'b0000;
      merge_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      merge_q  <= merge_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Outputs: strobes and ack are masked during reset so nothing escapes
  always_comb begin
    ack_pulse          = (state_q == RESP) && !rst;
    bus.m0_ack         = ack_pulse && !grant_q;
    bus.m1_ack         = ack_pulse && grant_q;
    bus.m0_rdata       = rdata0_q;
    bus.m1_rdata       = rdata1_q;
    bus.mem_addr       = addr_q;
    bus.mem_write_data = (state_q == MERGE_WR) ? merge_q : wdata_q;
    bus.mem_read       = mem_rd && !rst;
    bus.mem_write      = mem_wr && !rst;
    bus.busy           = (state_q != IDLE);
  end

endmodule
